// File: rtl/pwm_pkg.sv
// Shared mode encoding for the multi-channel PWM fader.
package pwm_pkg;

  typedef enum logic [1:0] {
    PWM_OFF    = 2'd0,
    PWM_DIRECT = 2'd1,
    PWM_RAMP   = 2'd2,
    PWM_BLINK  = 2'd3
  } pwm_mode_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active config, ramp duty register, compare and busy flag.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CTR_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               boundary,
  input  logic               ramp_tick,
  input  logic               blink_phase,
  input  logic [CTR_LEN-1:0] counter,
  input  logic               wr_en,
  input  pwm_mode_e          wr_mode,
  input  logic [CTR_LEN-1:0] wr_target,
  output logic               pwm,
  output logic               busy
);

  pwm_mode_e          shadow_mode_q, shadow_mode_d;
  pwm_mode_e          active_mode_q, active_mode_d;
  logic [CTR_LEN-1:0] shadow_target_q, shadow_target_d;
  logic [CTR_LEN-1:0] active_target_q, active_target_d;
  logic [CTR_LEN-1:0] duty_q, duty_d;
  logic [CTR_LEN-1:0] duty_eff;
  logic [CTR_LEN-1:0] ramp_base;
  logic               pwm_q, pwm_d;
  logic               busy_q, busy_d;

  always_comb begin
    case (active_mode_q)
      PWM_DIRECT: duty_eff = active_target_q;
      PWM_RAMP:   duty_eff = duty_q;
      PWM_BLINK:  duty_eff = blink_phase ? active_target_q : '0;
      default:    duty_eff = '0;
    endcase
  end

  always_comb begin
    shadow_mode_d   = shadow_mode_q;
    shadow_target_d = shadow_target_q;
    active_mode_d   = active_mode_q;
    active_target_d = active_target_q;
    duty_d          = duty_q;
    ramp_base       = '0;

    if (wr_en) begin
      shadow_mode_d   = wr_mode;
      shadow_target_d = wr_target;
    end

    if (boundary) begin
      active_mode_d   = shadow_mode_q;
      active_target_d = shadow_target_q;
      // Entering RAMP seeds the ramp from whatever duty was on show last period.
      if (shadow_mode_q == PWM_RAMP) begin
        ramp_base = (active_mode_q == PWM_RAMP) ? duty_q : duty_eff;
        if (ramp_tick) begin
          if (ramp_base < shadow_target_q) begin
            ramp_base = ramp_base + CTR_LEN'(1);
          end else if (ramp_base > shadow_target_q) begin
            ramp_base = ramp_base - CTR_LEN'(1);
          end
        end
        duty_d = ramp_base;
      end
    end

    pwm_d  = (duty_eff > counter);
    busy_d = (active_mode_d == PWM_RAMP) && (duty_d != active_target_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_mode_q   <= PWM_OFF;
      shadow_target_q <= '0;
      active_mode_q   <= PWM_OFF;
      active_target_q <= '0;
      duty_q          <= '0;
      pwm_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      shadow_mode_q   <= shadow_mode_d;
      shadow_target_q <= shadow_target_d;
      active_mode_q   <= active_mode_d;
      active_target_q <= active_target_d;
      duty_q          <= duty_d;
      pwm_q           <= pwm_d;
      busy_q          <= busy_d;
    end
  end

  assign pwm  = pwm_q;
  assign busy = busy_q;

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel PWM fader: shared period counter, ramp/blink dividers and config decode.
module pwm_fader
  import pwm_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CTR_LEN   = 8,
  parameter int RAMP_DIV  = 4,
  parameter int BLINK_DIV = 64,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CTR_LEN-1:0]  cfg_target,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] busy,
  output logic                period_start
);

  localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CTR_LEN-1:0] counter_q, counter_d;
  logic [RAMP_W-1:0]  ramp_div_q, ramp_div_d;
  logic [BLINK_W-1:0] blink_div_q, blink_div_d;
  logic               blink_phase_q, blink_phase_d;
  logic               period_start_q, period_start_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               boundary;
  logic               ramp_tick;

  always_comb begin
    counter_d      = counter_q + CTR_LEN'(1);
    boundary       = (counter_q == '1);
    ramp_div_d     = ramp_div_q;
    blink_div_d    = blink_div_q;
    blink_phase_d  = blink_phase_q;
    ramp_tick      = 1'b0;
    cfg_ready_d    = 1'b1;
    // period_start lands on the counter==0 cycle, so it is set from the boundary.
    period_start_d = boundary;

    if (boundary) begin
      if (ramp_div_q == RAMP_W'(RAMP_DIV - 1)) begin
        ramp_div_d = '0;
        ramp_tick  = 1'b1;
      end else begin
        ramp_div_d = ramp_div_q + RAMP_W'(1);
      end

      if (blink_div_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_div_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_div_d = blink_div_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      counter_q      <= '0;
      ramp_div_q     <= '0;
      blink_div_q    <= '0;
      blink_phase_q  <= 1'b0;
      period_start_q <= 1'b0;
      cfg_ready_q    <= 1'b0;
    end else begin
      counter_q      <= counter_d;
      ramp_div_q     <= ramp_div_d;
      blink_div_q    <= blink_div_d;
      blink_phase_q  <= blink_phase_d;
      period_start_q <= period_start_d;
      cfg_ready_q    <= cfg_ready_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .CTR_LEN(CTR_LEN)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .boundary   (boundary),
      .ramp_tick  (ramp_tick),
      .blink_phase(blink_phase_q),
      .counter    (counter_q),
      .wr_en      (cfg_valid && cfg_ready_q && (cfg_ch == CH_W'(i))),
      .wr_mode    (pwm_mode_e'(cfg_mode)),
      .wr_target  (cfg_target),
      .pwm        (pwm[i]),
      .busy       (busy[i])
    );
  end

  assign cfg_ready    = cfg_ready_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_fader.sv
// Bench for pwm_fader: per-cycle reference model plus directed period-level checks.
module tb_pwm_fader;

  localparam int CH = 3;
  localparam int CL = 3;
  localparam int RD = 2;
  localparam int BD = 1;
  localparam int P  = 1 << CL;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [CL-1:0] cfg_target;
  logic [CH-1:0] pwm;
  logic [CH-1:0] busy;
  logic          period_start;

  int checks = 0;
  int errors = 0;

  pwm_fader #(
    .CHANNELS (CH),
    .CTR_LEN  (CL),
    .RAMP_DIV (RD),
    .BLINK_DIV(BD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_target  (cfg_target),
    .pwm         (pwm),
    .busy        (busy),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after each posedge, built from the period/boundary rules.
  int s_mode[CH], s_tgt[CH], a_mode[CH], a_tgt[CH], duty[CH];
  int m_ctr, m_bcnt;
  bit m_phase, m_ps, m_ready, started;
  bit [CH-1:0] m_pwm, m_busy;

  task automatic model_step();
    int eff[CH];
    int base;
    bit bnd;
    bit tick;
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        s_mode[i] = 0; s_tgt[i] = 0; a_mode[i] = 0; a_tgt[i] = 0; duty[i] = 0;
      end
      m_ctr = 0; m_bcnt = 0; m_phase = 0; m_ps = 0; m_ready = 0;
      m_pwm = '0; m_busy = '0;
      return;
    end
    for (int i = 0; i < CH; i++) begin
      case (a_mode[i])
        0:       eff[i] = 0;
        1:       eff[i] = a_tgt[i];
        2:       eff[i] = duty[i];
        default: eff[i] = m_phase ? a_tgt[i] : 0;
      endcase
      m_pwm[i] = (eff[i] > m_ctr);
    end
    bnd  = (m_ctr == P - 1);
    tick = 0;
    if (bnd) begin
      m_bcnt++;
      tick = ((m_bcnt % RD) == 0);
      if ((m_bcnt % BD) == 0) m_phase = !m_phase;
      for (int i = 0; i < CH; i++) begin
        if (s_mode[i] == 2) begin
          base = (a_mode[i] == 2) ? duty[i] : eff[i];
          if (tick) begin
            if (base < s_tgt[i]) base++;
            else if (base > s_tgt[i]) base--;
          end
          duty[i] = base;
        end
        a_mode[i] = s_mode[i];
        a_tgt[i]  = s_tgt[i];
      end
    end
    if (cfg_valid && m_ready && int'(cfg_ch) < CH) begin
      s_mode[cfg_ch] = int'(cfg_mode);
      s_tgt[cfg_ch]  = int'(cfg_target);
    end
    for (int i = 0; i < CH; i++) m_busy[i] = (a_mode[i] == 2) && (duty[i] != a_tgt[i]);
    m_ps    = bnd;
    m_ctr   = (m_ctr + 1) % P;
    m_ready = 1;
  endtask

  always @(posedge clk) begin
    model_step();
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_pwm", int'(pwm), int'(m_pwm));
      check("model_busy", int'(busy), int'(m_busy));
      check("model_period_start", int'(period_start), int'(m_ps));
      check("model_cfg_ready", int'(cfg_ready), int'(m_ready));
    end
  end

  // ---- directed helpers ----
  int cnt[CH];

  task automatic do_write(input int ch, input int mode, input int tgt);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_target = CL'(tgt);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2 * P);
    if (!period_start) begin
      checks++;
      errors++;
      $display("FAIL wait_ps: no period_start within %0d cycles", 2 * P);
    end
  endtask

  // Called on a period_start negedge; ends on the next one.
  task automatic count_period();
    for (int i = 0; i < CH; i++) cnt[i] = 0;
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) cnt[i] += int'(pwm[i]);
    end
  endtask

  task automatic ps_latency(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 4 * P);
    check(name, n, P);
  endtask

  typedef struct {
    int ch;
    int mode;
    int tgt;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6];
  int   prev, a, b;

  initial begin
    vecs[0] = '{0, 1, 3, 3};
    vecs[1] = '{1, 1, 7, 7};
    vecs[2] = '{2, 1, 1, 1};
    vecs[3] = '{1, 0, 5, 0};
    vecs[4] = '{0, 1, 0, 0};
    vecs[5] = '{2, 1, 5, 5};

    rst = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_target = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(cfg_ready), 0);
    check("reset_ps", int'(period_start), 0);
    rst = 1'b1;
    ps_latency("first_ps_latency");
    count_period();
    check("idle_all_low", cnt[0] + cnt[1] + cnt[2], 0);

    for (int v = 0; v < 6; v++) begin
      do_write(vecs[v].ch, vecs[v].mode, vecs[v].tgt);
      wait_ps();
      count_period();
      check($sformatf("vec%0d_high_cycles", v), cnt[vecs[v].ch], vecs[v].exp_cnt);
      if (v == 0) check("vec0_others_low", cnt[1] + cnt[2], 0);
    end

    // Last write in a period wins; a boundary-cycle write waits one more period.
    do_write(1, 1, 5);
    do_write(1, 1, 2);
    wait_ps();
    count_period();
    check("last_write_wins", cnt[1], 2);
    repeat (P - 1) @(negedge clk);
    do_write(1, 1, 6);
    count_period();
    check("boundary_write_deferred", cnt[1], 2);
    count_period();
    check("boundary_write_applied", cnt[1], 6);

    // Ramp up from 0 to 4, then back down to 1.
    do_write(2, 1, 0);
    wait_ps();
    count_period();
    do_write(2, 2, 4);
    wait_ps();
    check("ramp_busy_rises", int'(busy[2]), 1);
    prev = 0;
    for (int k = 0; k < 14 && prev != 4; k++) begin
      count_period();
      check("ramp_up_step", (cnt[2] >= prev && cnt[2] <= prev + 1) ? 1 : 0, 1);
      prev = cnt[2];
    end
    check("ramp_up_final", prev, 4);
    check("ramp_busy_falls", int'(busy[2]), 0);
    do_write(2, 2, 1);
    wait_ps();
    for (int k = 0; k < 12 && prev != 1; k++) begin
      count_period();
      check("ramp_down_step", (cnt[2] <= prev && cnt[2] >= prev - 1) ? 1 : 0, 1);
      prev = cnt[2];
    end
    check("ramp_down_final", prev, 1);
    check("ramp_down_idle", int'(busy[2]), 0);

    // Blink toggles each period with BLINK_DIV=1.
    do_write(0, 3, 7);
    wait_ps();
    count_period();
    a = cnt[0];
    count_period();
    b = cnt[0];
    check("blink_sum", a + b, 7);
    check("blink_low_period", (a < b) ? a : b, 0);
    do_write(0, 0, 7);
    wait_ps();
    count_period();
    check("off_low", cnt[0], 0);

    // Out-of-range channel is accepted and ignored.
    do_write(3, 1, 7);
    wait_ps();
    count_period();
    check("oor_ch0", cnt[0], 0);
    check("oor_ch1", cnt[1], 6);
    check("oor_ch2", cnt[2], 1);

    // Reset in the middle of a ramp.
    do_write(2, 2, 7);
    wait_ps();
    count_period();
    repeat (3) @(negedge clk);
    check("pre_reset_busy", int'(busy[2]), 1);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_pwm", int'(pwm), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_ready", int'(cfg_ready), 0);
    check("midreset_ps", int'(period_start), 0);
    rst = 1'b1;
    ps_latency("ps_latency_after_reset");

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_target = CL'($urandom_range(0, P - 1));
      rst        = ($urandom_range(0, 249) != 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    repeat (2 * P) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
